// File: rtl/led_ctrl_pkg.sv
// Shared types and default sizing for the LED blink controller.
// Optional inter-burst gap is enabled by defining LED_GAP_EN.
package led_ctrl_pkg;

    localparam int unsigned DEF_NUM_REQ   = 2;
    localparam int unsigned DEF_CNT_W     = 4;
    localparam int unsigned DEF_TICK_DIV  = 4;
    localparam int unsigned DEF_GAP_TICKS = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } led_state_t;

    // Index width that stays legal for a single-entry range.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_blink_arbiter_if.sv
// Requester-side bundle of the LED blink arbiter: requests in, grant/status/LED out.
interface led_blink_arbiter_if
    import led_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned CNT_W   = DEF_CNT_W
);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] blink_count;
    logic [NUM_REQ-1:0]       grant;
    logic                     done;
    logic                     busy;
    logic                     light_on;

    modport master (
        output req, blink_count,
        input  grant, done, busy, light_on
    );

    modport slave (
        input  req, blink_count,
        output grant, done, busy, light_on
    );

endinterface

// File: rtl/led_tick_prescaler.sv
// Free-running phase timer: tick is high on the last of every TICK_DIV cycles; clear restarts the count.
module led_tick_prescaler
    import led_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned   PW   = idx_w(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt;
    logic [PW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt + PW'(1);
        if (clear || (cnt == LAST)) cnt_nxt = '0;
    end

    // tick is registered from the next count so it lines up with cnt == LAST
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tick <= (cnt_nxt == LAST);
        end
    end

endmodule

// File: rtl/led_blink_arbiter.sv
// Round-robin sharing of one LED between requesters, each asking for a burst of blinks.
// Define LED_GAP_EN to insert GAP_TICKS dark ticks after every burst.
module led_blink_arbiter
    import led_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
    parameter int unsigned GAP_TICKS = DEF_GAP_TICKS
) (
    input  logic                clock,
    input  logic                reset,
    led_blink_arbiter_if.slave  bus
);

    localparam int unsigned IW = idx_w(NUM_REQ);

    if (NUM_REQ < 1 || TICK_DIV < 2 || GAP_TICKS < 1) begin : g_bad_param
        $error("led_blink_arbiter: illegal parameter set");
    end

`ifdef LED_GAP_EN
    localparam led_state_t  ST_END = ST_GAP;
    localparam int unsigned GW     = idx_w(GAP_TICKS);
    logic [GW-1:0] gap_cnt;
`else
    localparam led_state_t  ST_END = ST_IDLE;
`endif

    led_state_t         state;
    led_state_t         state_nxt;
    logic [CNT_W-1:0]   count;
    logic [NUM_REQ-1:0] owner;
    logic [IW-1:0]      rr_ptr;
    logic               tick;
    logic               win_found;
    logic [IW-1:0]      win_idx;
    logic [CNT_W-1:0]   win_count;
    logic               last_blink;
    int                 probe;

    led_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (state_nxt != state),
        .tick  (tick)
    );

    // First set request at or after rr_ptr, wrapping; descending scan so the nearest wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        probe     = 0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            probe = (int'(rr_ptr) + i) % int'(NUM_REQ);
            if (bus.req[probe]) begin
                win_found = 1'b1;
                win_idx   = IW'(probe);
            end
        end
        win_count = bus.blink_count[int'(win_idx)*CNT_W +: CNT_W];
    end

    // A zero-count burst ends in its first (and only) cycle
    assign last_blink = (count == '0) || (tick && (count == CNT_W'(1)));

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (win_found) state_nxt = (win_count == '0) ? ST_OFF : ST_ON;
            ST_ON:   if (tick) state_nxt = ST_OFF;
            ST_OFF: begin
                if (last_blink) state_nxt = ST_END;
                else if (tick)  state_nxt = ST_ON;
            end
`ifdef LED_GAP_EN
            ST_GAP:  if (tick && (gap_cnt == GW'(GAP_TICKS - 1))) state_nxt = ST_IDLE;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.light_on = (state == ST_ON);
        bus.busy     = (state != ST_IDLE);
        bus.grant    = (state == ST_ON || state == ST_OFF) ? owner : '0;
        bus.done     = (state == ST_OFF) && last_blink;
    end

    // Winner latch, round-robin pointer and blink countdown
    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            owner  <= '0;
            rr_ptr <= '0;
        end else if (state == ST_IDLE && win_found) begin
            count  <= win_count;
            owner  <= NUM_REQ'(1) << win_idx;
            rr_ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
        end else if (state == ST_OFF && tick && count != '0) begin
            count  <= count - CNT_W'(1);
        end
    end

`ifdef LED_GAP_EN
    always_ff @(posedge clock) begin
        if (reset || state != ST_GAP) gap_cnt <= '0;
        else if (tick)                gap_cnt <= gap_cnt + GW'(1);
    end
`endif

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed plus random bench for led_blink_arbiter, checked against a burst-level timeline model.
module tb_led_blink_arbiter;

    localparam int NR  = 2;
    localparam int CW  = 4;
    localparam int TD  = 4;
    localparam int GT  = 2;
`ifdef LED_GAP_EN
    localparam int GAP_CYC = GT * TD;
`else
    localparam int GAP_CYC = 0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   rr_m;
    logic [1:0] fg [4];
    logic [1:0] g0;

    led_blink_arbiter_if #(.NUM_REQ(NR), .CNT_W(CW)) bus ();

    led_blink_arbiter #(.NUM_REQ(NR), .CNT_W(CW), .TICK_DIV(TD), .GAP_TICKS(GT)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input logic exp_busy);
        chk({tag, "_grant"}, 32'(bus.grant), 32'(0));
        chk({tag, "_light"}, 32'(bus.light_on), 32'(0));
        chk({tag, "_done"},  32'(bus.done), 32'(0));
        chk({tag, "_busy"},  32'(bus.busy), 32'(exp_busy));
    endtask

    // Round-robin pick from the model pointer
    function automatic int pick(input logic [NR-1:0] r, input int ptr);
        for (int i = 0; i < NR; i++) begin
            if (r[(ptr + i) % NR]) return (ptr + i) % NR;
        end
        return -1;
    endfunction

    // Called at a negedge with the DUT idle and inputs set; walks the whole burst, gap and idle cycle.
    task automatic do_burst(input bit scramble, output logic [1:0] first_grant);
        int w;
        int n;
        int len;
        logic [CW-1:0] f;
        w = pick(bus.req, rr_m);
        f = bus.blink_count[w*CW +: CW];
        n = int'(f);
        len = (n == 0) ? 1 : 2 * n * TD;
        rr_m = (w + 1) % NR;
        first_grant = '0;
        for (int t = 0; t < len; t++) begin
            @(negedge clk);
            if (t == 0) first_grant = bus.grant;
            chk("burst_grant", 32'(bus.grant), 32'(1 << w));
            chk("burst_light", 32'(bus.light_on), 32'((n > 0) && ((t % (2 * TD)) < TD)));
            chk("burst_done",  32'(bus.done), 32'(t == len - 1));
            chk("burst_busy",  32'(bus.busy), 32'(1));
            if (scramble && t == 0) begin
                bus.req         = 2'($urandom);
                bus.blink_count = 8'($urandom);
            end
        end
        for (int g = 0; g < GAP_CYC; g++) begin
            @(negedge clk);
            chk_quiet("gap", 1'b1);
        end
        @(negedge clk);
        chk_quiet("idle_after", 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rr_m  = 0;
        rst   = 1'b1;
        bus.req = '0;
        bus.blink_count = '0;
        @(negedge clk);
        @(negedge clk);
        chk_quiet("reset", 1'b0);
        rst = 1'b0;

        // Contention from reset: req0 (1 blink) then req1 (2 blinks)
        bus.req = 2'b11;
        bus.blink_count = {4'd2, 4'd1};
        do_burst(1'b0, g0);
        chk("contention_first", 32'(g0), 32'(2'b01));
        bus.req = 2'b11;
        bus.blink_count = {4'd2, 4'd1};
        do_burst(1'b0, g0);
        chk("contention_second", 32'(g0), 32'(2'b10));

        // Fairness with both held
        for (int k = 0; k < 4; k++) begin
            bus.req = 2'b11;
            bus.blink_count = {4'($urandom_range(1, 2)), 4'($urandom_range(1, 2))};
            do_burst(1'b0, fg[k]);
        end
        chk("fair0", 32'(fg[0]), 32'(2'b01));
        chk("fair1", 32'(fg[1]), 32'(2'b10));
        chk("fair2", 32'(fg[2]), 32'(2'b01));
        chk("fair3", 32'(fg[3]), 32'(2'b10));

        // Single requester, 3 blinks
        bus.req = 2'b01;
        bus.blink_count = {4'd5, 4'd3};
        do_burst(1'b0, g0);

        // Zero count on requester 1
        bus.req = 2'b10;
        bus.blink_count = {4'd0, 4'd7};
        do_burst(1'b0, g0);
        chk("zero_grant", 32'(g0), 32'(2'b10));

        // Reset during an ON phase of requester 1
        bus.req = 2'b01;
        bus.blink_count = {4'd2, 4'd1};
        do_burst(1'b0, g0);
        bus.req = 2'b11;
        @(negedge clk);
        chk("pre_reset_grant", 32'(bus.grant), 32'(2'b10));
        chk("pre_reset_light", 32'(bus.light_on), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("mid_reset", 1'b0);
        rst  = 1'b0;
        rr_m = 0;
        do_burst(1'b0, g0);
        chk("post_reset_winner", 32'(g0), 32'(2'b01));

        // Random traffic with mid-burst input churn
        for (int k = 0; k < 40; k++) begin
            bus.req = 2'($urandom);
            bus.blink_count = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            if (bus.req == '0) begin
                @(negedge clk);
                chk_quiet("rand_idle", 1'b0);
            end else begin
                do_burst(1'b1, g0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
